// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2
    } rx_state_e;

    typedef enum logic [1:0] {
        DATA_BITS_5 = 2'b00,
        DATA_BITS_6 = 2'b01,
        DATA_BITS_7 = 2'b10,
        DATA_BITS_8 = 2'b11
    } data_bits_e;

    typedef enum logic {
        PARITY_EVEN = 1'b0,
        PARITY_ODD  = 1'b1
    } parity_mode_e;

    localparam int OVERSAMPLE_DEFAULT = 16;
    localparam int SAMPLE_FIRST       = 7;
    localparam int SAMPLE_MID         = 8;
    localparam int SAMPLE_LAST        = 9;

    // Index of the final data bit for a given data-width encoding.
    function automatic logic [2:0] lastDataIndex(input logic [1:0] cfg);
        case (cfg)
            DATA_BITS_5: return 3'd4;
            DATA_BITS_6: return 3'd5;
            DATA_BITS_7: return 3'd6;
            default:     return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_bit_sampler.sv
// Synchronizes rxd, counts oversample ticks within a bit and votes 2-of-3 at mid-bit.
module uart_rx_bit_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = OVERSAMPLE_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_tick,
    input  logic rxd,
    input  logic run_i,
    output logic rxd_sync_o,
    output logic bit_valid_o,
    output logic bit_value_o,
    output logic bit_end_o
);

    localparam int CW = $clog2(OVERSAMPLE);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          tickCnt_q;
    logic [1:0]             vote_q;
    logic                   rxdSync;

    assign rxdSync = sync_q[SYNC_STAGES-1];

    // The counter is held at zero while the FSM is idle so the first tick after
    // the start edge is count 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '1;
            tickCnt_q <= '0;
            vote_q    <= 2'b11;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
            if (!run_i) begin
                tickCnt_q <= '0;
            end else if (sample_tick) begin
                if (tickCnt_q == CW'(OVERSAMPLE - 1))
                    tickCnt_q <= '0;
                else
                    tickCnt_q <= tickCnt_q + 1'b1;
                if (tickCnt_q == CW'(SAMPLE_FIRST))
                    vote_q[0] <= rxdSync;
                if (tickCnt_q == CW'(SAMPLE_MID))
                    vote_q[1] <= rxdSync;
            end
        end
    end

    assign rxd_sync_o  = rxdSync;
    assign bit_valid_o = run_i & sample_tick & (tickCnt_q == CW'(SAMPLE_LAST));
    assign bit_end_o   = run_i & sample_tick & (tickCnt_q == CW'(OVERSAMPLE - 1));
    assign bit_value_o = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxdSync) | (vote_q[1] & rxdSync);

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART frame receiver with valid/ready output and error flags.
// Optional break detection is enabled by defining UART_RX_BREAK_DETECT_EN.
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = OVERSAMPLE_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_tick,
    input  logic       rxd,
    input  logic [1:0] cfg_data_bits,
    input  logic       cfg_parity_en,
    input  logic       cfg_parity_odd,
    input  logic       cfg_stop2,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun_err,
`ifdef UART_RX_BREAK_DETECT_EN
    output logic       break_det,
`endif
    input  logic       err_clr
);

    rx_state_e  state_q;
    logic [1:0] cfgDataBits_q;
    logic       cfgParityEn_q, cfgParityOdd_q, cfgStop2_q;
    logic [2:0] bitIdx_q;
    logic [7:0] shift_q;
    logic       parAcc_q, parErr_q, stopErr_q;
    logic [7:0] rxData_q;
    logic       rxValid_q, parityErr_q, frameErr_q, overrun_q;
    logic       rxdSync, bitValid, bitValue, bitEnd;
    logic       frameDone, frameErrD, breakD, deliver;
`ifdef UART_RX_BREAK_DETECT_EN
    logic       allZero_q, holdLine_q, breakDet_q;
`endif

    uart_rx_bit_sampler #(
        .OVERSAMPLE (OVERSAMPLE),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sampler (
        .clk        (clk),
        .rst        (rst),
        .sample_tick(sample_tick),
        .rxd        (rxd),
        .run_i      (state_q != ST_IDLE),
        .rxd_sync_o (rxdSync),
        .bit_valid_o(bitValid),
        .bit_value_o(bitValue),
        .bit_end_o  (bitEnd)
    );

    // A frame completes at the mid-bit decision of its last stop bit.
    always_comb begin
        frameDone = 1'b0;
        frameErrD = 1'b0;
        breakD    = 1'b0;
        if (bitValid) begin
            case (state_q)
                ST_STOP1: if (!cfgStop2_q) begin
                    frameDone = 1'b1;
                    frameErrD = ~bitValue;
                end
                ST_STOP2: begin
                    frameDone = 1'b1;
                    frameErrD = stopErr_q | ~bitValue;
                end
                default: ;
            endcase
        end
`ifdef UART_RX_BREAK_DETECT_EN
        breakD = frameDone & allZero_q & ~bitValue;
`endif
        deliver = frameDone & ~breakD;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cfgDataBits_q  <= 2'b00;
            cfgParityEn_q  <= 1'b0;
            cfgParityOdd_q <= 1'b0;
            cfgStop2_q     <= 1'b0;
            bitIdx_q       <= 3'd0;
            shift_q        <= 8'h00;
            parAcc_q       <= 1'b0;
            parErr_q       <= 1'b0;
            stopErr_q      <= 1'b0;
            rxData_q       <= 8'h00;
            rxValid_q      <= 1'b0;
            parityErr_q    <= 1'b0;
            frameErr_q     <= 1'b0;
            overrun_q      <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            allZero_q      <= 1'b0;
            holdLine_q     <= 1'b0;
            breakDet_q     <= 1'b0;
`endif
        end else begin
            // Overrun must win over a same-cycle clear, so the clear is written first.
            if (err_clr)
                overrun_q <= 1'b0;
            if (deliver) begin
                if (rxValid_q && !rx_ready) begin
                    overrun_q <= 1'b1;
                end else begin
                    rxData_q    <= shift_q;
                    rxValid_q   <= 1'b1;
                    parityErr_q <= parErr_q;
                    frameErr_q  <= frameErrD;
                end
            end else if (rxValid_q && rx_ready) begin
                rxValid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
`ifdef UART_RX_BREAK_DETECT_EN
                    if (holdLine_q) begin
                        if (sample_tick && rxdSync)
                            holdLine_q <= 1'b0;
                    end else
`endif
                    if (sample_tick && !rxdSync) begin
                        state_q        <= ST_START;
                        cfgDataBits_q  <= cfg_data_bits;
                        cfgParityEn_q  <= cfg_parity_en;
                        cfgParityOdd_q <= cfg_parity_odd;
                        cfgStop2_q     <= cfg_stop2;
                        bitIdx_q       <= 3'd0;
                        shift_q        <= 8'h00;
                        parAcc_q       <= 1'b0;
                        parErr_q       <= 1'b0;
                        stopErr_q      <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
                        allZero_q      <= 1'b1;
`endif
                    end
                end
                ST_START: begin
                    if (bitValid && bitValue)
                        state_q <= ST_IDLE;
                    else if (bitEnd)
                        state_q <= ST_DATA;
                end
                ST_DATA: begin
                    if (bitValid) begin
                        shift_q[bitIdx_q] <= bitValue;
                        parAcc_q          <= parAcc_q ^ bitValue;
`ifdef UART_RX_BREAK_DETECT_EN
                        allZero_q         <= allZero_q & ~bitValue;
`endif
                    end
                    if (bitEnd) begin
                        if (bitIdx_q == lastDataIndex(cfgDataBits_q))
                            state_q <= cfgParityEn_q ? ST_PARITY : ST_STOP1;
                        else
                            bitIdx_q <= bitIdx_q + 3'd1;
                    end
                end
                ST_PARITY: begin
                    if (bitValid) begin
                        parErr_q <= bitValue != (parAcc_q ^ (parity_mode_e'(cfgParityOdd_q) == PARITY_ODD));
`ifdef UART_RX_BREAK_DETECT_EN
                        allZero_q <= allZero_q & ~bitValue;
`endif
                    end
                    if (bitEnd)
                        state_q <= ST_STOP1;
                end
                ST_STOP1: begin
                    if (bitValid) begin
                        if (!cfgStop2_q) begin
                            state_q <= ST_IDLE;
                        end else begin
                            stopErr_q <= ~bitValue;
`ifdef UART_RX_BREAK_DETECT_EN
                            allZero_q <= allZero_q & ~bitValue;
`endif
                        end
                    end
                    if (bitEnd)
                        state_q <= ST_STOP2;
                end
                ST_STOP2: begin
                    if (bitValid)
                        state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase

`ifdef UART_RX_BREAK_DETECT_EN
            breakDet_q <= breakD;
            if (breakD)
                holdLine_q <= 1'b1;
`endif
        end
    end

    assign rx_data     = rxData_q;
    assign rx_valid    = rxValid_q;
    assign parity_err  = parityErr_q;
    assign frame_err   = frameErr_q;
    assign overrun_err = overrun_q;
`ifdef UART_RX_BREAK_DETECT_EN
    assign break_det   = breakDet_q;
`endif

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: 4-clock sample tick, 64 clocks per bit.
module tb_uart_rx_deserializer;

    localparam int BITCLK = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       sampleTick;
    logic       rxd;
    logic [1:0] cfgDataBits;
    logic       cfgParityEn, cfgParityOdd, cfgStop2;
    logic [7:0] rxData;
    logic       rxValid, rxReady;
    logic       parityErr, frameErr, overrunErr, errClr;
`ifdef UART_RX_BREAK_DETECT_EN
    logic       breakDet;
`endif

    int  total = 0;
    int  bad   = 0;
    int  tickDiv = 0;
    logic early;

    uart_rx_deserializer dut (
        .clk           (clk),
        .rst           (rst),
        .sample_tick   (sampleTick),
        .rxd           (rxd),
        .cfg_data_bits (cfgDataBits),
        .cfg_parity_en (cfgParityEn),
        .cfg_parity_odd(cfgParityOdd),
        .cfg_stop2     (cfgStop2),
        .rx_data       (rxData),
        .rx_valid      (rxValid),
        .rx_ready      (rxReady),
        .parity_err    (parityErr),
        .frame_err     (frameErr),
        .overrun_err   (overrunErr),
`ifdef UART_RX_BREAK_DETECT_EN
        .break_det     (breakDet),
`endif
        .err_clr       (errClr)
    );

    always #5 clk = ~clk;

    // One-cycle tick every fourth clock, changed on the falling edge.
    always @(negedge clk) begin
        sampleTick = (tickDiv == 3);
        tickDiv    = (tickDiv + 1) % 4;
    end

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic holdLine(input logic v, input int clocks);
        rxd = v;
        repeat (clocks) @(negedge clk);
    endtask

    // Sends one frame; early reports rx_valid 52 clocks into the last stop bit.
    task automatic applyStimulus(input logic [7:0] d, input int nBits, input logic parEn,
                                 input logic parOdd, input logic stop2, input logic flipPar,
                                 input logic stopVal, output logic earlyValid);
        logic [7:0] mask;
        logic       p;
        mask         = 8'hFF >> (8 - nBits);
        cfgDataBits  = 2'(nBits - 5);
        cfgParityEn  = parEn;
        cfgParityOdd = parOdd;
        cfgStop2     = stop2;
        holdLine(1'b0, BITCLK);
        for (int i = 0; i < nBits; i++)
            holdLine(d[i], BITCLK);
        if (parEn) begin
            p = (^(d & mask)) ^ parOdd ^ flipPar;
            holdLine(p, BITCLK);
        end
        if (stop2)
            holdLine(stopVal, BITCLK);
        holdLine(stopVal, 52);
        earlyValid = rxValid;
        holdLine(stopVal, 12);
        holdLine(1'b1, 2 * BITCLK);
    endtask

    task automatic acceptFrame(input string tag);
        rxReady = 1'b1;
        @(negedge clk);
        rxReady = 1'b0;
        @(negedge clk);
        checkOutput(tag, 16'(rxValid), 16'h0);
    endtask

    initial begin
        rst = 1'b1; rxd = 1'b1; rxReady = 1'b0; errClr = 1'b0;
        cfgDataBits = 2'b11; cfgParityEn = 1'b0; cfgParityOdd = 1'b0; cfgStop2 = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_data", 16'(rxData), 16'h0);
        checkOutput("rst_valid", 16'(rxValid), 16'h0);
        checkOutput("rst_perr", 16'(parityErr), 16'h0);
        checkOutput("rst_ferr", 16'(frameErr), 16'h0);
        checkOutput("rst_ovr", 16'(overrunErr), 16'h0);
        holdLine(1'b1, BITCLK);

        $display("[TB] 8N1 0xA5");
        applyStimulus(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, early);
        checkOutput("a5_early", 16'(early), 16'h1);
        checkOutput("a5_data", 16'(rxData), 16'hA5);
        checkOutput("a5_valid", 16'(rxValid), 16'h1);
        checkOutput("a5_perr", 16'(parityErr), 16'h0);
        checkOutput("a5_ferr", 16'(frameErr), 16'h0);
        acceptFrame("a5_accept");

        $display("[TB] 7E1 0x35 bad parity");
        applyStimulus(8'h35, 7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, early);
        checkOutput("35_data", 16'(rxData), 16'h35);
        checkOutput("35_valid", 16'(rxValid), 16'h1);
        checkOutput("35_perr", 16'(parityErr), 16'h1);
        checkOutput("35_ferr", 16'(frameErr), 16'h0);
        acceptFrame("35_accept");

        $display("[TB] 8O2 0x96 good parity");
        applyStimulus(8'h96, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, early);
        checkOutput("96_data", 16'(rxData), 16'h96);
        checkOutput("96_perr", 16'(parityErr), 16'h0);
        checkOutput("96_ferr", 16'(frameErr), 16'h0);
        acceptFrame("96_accept");

        $display("[TB] false start then 0x5A");
        holdLine(1'b0, 16);
        holdLine(1'b1, 100);
        checkOutput("false_valid", 16'(rxValid), 16'h0);
        holdLine(1'b1, BITCLK);
        applyStimulus(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, early);
        checkOutput("5a_data", 16'(rxData), 16'h5A);
        checkOutput("5a_valid", 16'(rxValid), 16'h1);
        checkOutput("5a_ferr", 16'(frameErr), 16'h0);
        acceptFrame("5a_accept");

        $display("[TB] 8N1 0x3C bad stop");
        applyStimulus(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, early);
        checkOutput("3c_data", 16'(rxData), 16'h3C);
        checkOutput("3c_ferr", 16'(frameErr), 16'h1);
        checkOutput("3c_perr", 16'(parityErr), 16'h0);
        acceptFrame("3c_accept");

        $display("[TB] overrun 0x11 then 0x22");
        applyStimulus(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, early);
        checkOutput("ovr_first_flag", 16'(overrunErr), 16'h0);
        applyStimulus(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, early);
        checkOutput("ovr_data", 16'(rxData), 16'h11);
        checkOutput("ovr_valid", 16'(rxValid), 16'h1);
        checkOutput("ovr_flag", 16'(overrunErr), 16'h1);
        errClr = 1'b1;
        @(negedge clk);
        errClr = 1'b0;
        @(negedge clk);
        checkOutput("ovr_cleared", 16'(overrunErr), 16'h0);
        checkOutput("ovr_data_kept", 16'(rxData), 16'h11);
        acceptFrame("ovr_accept");

        $display("[TB] reset mid-frame then 0xC3");
        applyStimulus(8'h77, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, early);
        checkOutput("77_pending", 16'(rxValid), 16'h1);
        holdLine(1'b0, BITCLK);
        holdLine(1'b0, 3 * BITCLK);
        holdLine(1'b0, 32);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rxd = 1'b1;
        @(negedge clk);
        checkOutput("mrst_data", 16'(rxData), 16'h0);
        checkOutput("mrst_valid", 16'(rxValid), 16'h0);
        checkOutput("mrst_perr", 16'(parityErr), 16'h0);
        checkOutput("mrst_ferr", 16'(frameErr), 16'h0);
        checkOutput("mrst_ovr", 16'(overrunErr), 16'h0);
        holdLine(1'b1, 2 * BITCLK);
        applyStimulus(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, early);
        checkOutput("c3_data", 16'(rxData), 16'hC3);
        checkOutput("c3_valid", 16'(rxValid), 16'h1);
        checkOutput("c3_perr", 16'(parityErr), 16'h0);
        checkOutput("c3_ferr", 16'(frameErr), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
